// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the mips32 memory arbiter, its three requesters and the memory array.
interface mips32_mem_arbiter_if #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) ();
  logic          ld_req,   dm_req,   if_req;
  logic          ld_we,    dm_we;
  logic [AW-1:0] ld_addr,  dm_addr,  if_addr;
  logic [DW-1:0] ld_wdata, dm_wdata;
  logic          ld_lock;
  logic          cpu_halted;

  logic          ld_gnt,    dm_gnt,    if_gnt;
  logic          ld_rvalid, dm_rvalid, if_rvalid;
  logic [DW-1:0] ld_rdata,  dm_rdata,  if_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          locked;

  modport slave (
    input  ld_req, dm_req, if_req, ld_we, dm_we, ld_addr, dm_addr, if_addr,
           ld_wdata, dm_wdata, ld_lock, cpu_halted, mem_rdata,
    output ld_gnt, dm_gnt, if_gnt, ld_rvalid, dm_rvalid, if_rvalid,
           ld_rdata, dm_rdata, if_rdata, mem_en, mem_we, mem_addr, mem_wdata, locked
  );

  modport master (
    output ld_req, dm_req, if_req, ld_we, dm_we, ld_addr, dm_addr, if_addr,
           ld_wdata, dm_wdata, ld_lock, cpu_halted, mem_rdata,
    input  ld_gnt, dm_gnt, if_gnt, ld_rvalid, dm_rvalid, if_rvalid,
           ld_rdata, dm_rdata, if_rdata, mem_en, mem_we, mem_addr, mem_wdata, locked
  );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Shares the single-port unified memory between loader, data stage and fetch;
// one access per cycle, fetch anti-starvation boost and an exclusive loader lock.
module mips32_mem_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips32_mem_arbiter_if.slave  bus
);

  localparam int unsigned CW = 4;

  typedef enum logic { S_NORMAL, S_LOCKED } state_t;
  typedef enum logic [1:0] { OWN_NONE, OWN_LD, OWN_DM, OWN_IF } owner_t;

  state_t        r_state, w_state_nxt;
  owner_t        r_owner, w_owner_nxt;
  logic [CW-1:0] r_fcnt,  w_fcnt_nxt;

  logic          w_ld_gnt, w_dm_gnt, w_if_gnt;
  logic          w_if_elig, w_boost;
  logic          w_mem_en, w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [DW-1:0] w_mem_wdata;

  // State, fetch starvation counter and read-owner tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_NORMAL;
      r_owner <= OWN_NONE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  // Grant selection, next state and memory command mux
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = OWN_NONE;
    w_fcnt_nxt  = r_fcnt;
    w_ld_gnt    = 1'b0;
    w_dm_gnt    = 1'b0;
    w_if_gnt    = 1'b0;
    w_mem_en    = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_if_elig   = bus.if_req && !bus.cpu_halted;
    w_boost     = (r_fcnt == CW'(STARVE_LIMIT));

    // Grants are suppressed while reset is asserted so outputs clear immediately
    if (rst_n) begin
      case (r_state)
        S_NORMAL: begin
          if (bus.ld_req)                w_ld_gnt = 1'b1;
          else if (w_if_elig && w_boost) w_if_gnt = 1'b1;
          else if (bus.dm_req)           w_dm_gnt = 1'b1;
          else if (w_if_elig)            w_if_gnt = 1'b1;

          if (w_ld_gnt && bus.ld_lock) w_state_nxt = S_LOCKED;

          if (!bus.if_req || w_if_gnt)   w_fcnt_nxt = '0;
          else if (w_if_elig && !w_boost) w_fcnt_nxt = r_fcnt + CW'(1);
        end
        S_LOCKED: begin
          w_ld_gnt = bus.ld_req;
          if (!bus.ld_lock) w_state_nxt = S_NORMAL;
        end
        default: w_state_nxt = S_NORMAL;
      endcase
    end

    if (w_ld_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.ld_we;
      w_mem_addr  = bus.ld_addr;
      w_mem_wdata = bus.ld_wdata;
      w_owner_nxt = bus.ld_we ? OWN_NONE : OWN_LD;
    end else if (w_dm_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_we    = bus.dm_we;
      w_mem_addr  = bus.dm_addr;
      w_mem_wdata = bus.dm_wdata;
      w_owner_nxt = bus.dm_we ? OWN_NONE : OWN_DM;
    end else if (w_if_gnt) begin
      w_mem_en    = 1'b1;
      w_mem_addr  = bus.if_addr;
      w_owner_nxt = OWN_IF;
    end
  end

  assign bus.ld_gnt    = w_ld_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.if_gnt    = w_if_gnt;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  // Read data is steered to whoever owned last cycle's read strobe
  assign bus.ld_rvalid = (r_owner == OWN_LD);
  assign bus.dm_rvalid = (r_owner == OWN_DM);
  assign bus.if_rvalid = (r_owner == OWN_IF);
  assign bus.ld_rdata  = bus.ld_rvalid ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.locked    = (r_state == S_LOCKED);

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter: behavioural memory, reference array and
// a read-return scoreboard checked every cycle with immediate assertions.
module tb_mips32_mem_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst_n;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bif ();

  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory
  logic [DW-1:0] mem [0:1023];
  logic [DW-1:0] r_mrd;
  always @(posedge clk) begin
    if (bif.mem_en) begin
      if (bif.mem_we) mem[bif.mem_addr] <= bif.mem_wdata;
      else            r_mrd <= mem[bif.mem_addr];
    end
  end
  assign bif.mem_rdata = r_mrd;

  typedef struct { int own; logic [DW-1:0] data; } sb_t;
  sb_t           sb [$];
  logic [DW-1:0] ref_mem [0:1023];
  bit            exp_lock;
  int            n_pass = 0;
  int            n_tot  = 0;
  int            n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // w: 0 none, 1 loader, 2 data stage, 3 fetch
  task automatic check_cycle(input int w);
    sb_t           e;
    logic [2:0]    exp_rv;
    logic [DW-1:0] exp_d [3];
    logic [2:0]    exp_g;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    exp_rv = 3'b000;
    exp_d[0] = '0; exp_d[1] = '0; exp_d[2] = '0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      exp_rv = 3'b100 >> (e.own - 1);
      exp_d[e.own-1] = e.data;
    end
    chk("rvalid",   {bif.ld_rvalid, bif.dm_rvalid, bif.if_rvalid}, 64'(exp_rv));
    chk("ld_rdata", 64'(bif.ld_rdata), 64'(exp_d[0]));
    chk("dm_rdata", 64'(bif.dm_rdata), 64'(exp_d[1]));
    chk("if_rdata", 64'(bif.if_rdata), 64'(exp_d[2]));

    e_we = 1'b0; e_addr = '0; e_wd = '0; exp_g = 3'b000;
    case (w)
      1: begin exp_g = 3'b100; e_we = bif.ld_we; e_addr = bif.ld_addr; e_wd = bif.ld_wdata; end
      2: begin exp_g = 3'b010; e_we = bif.dm_we; e_addr = bif.dm_addr; e_wd = bif.dm_wdata; end
      3: begin exp_g = 3'b001; e_addr = bif.if_addr; end
      default: ;
    endcase
    chk("gnt",       {bif.ld_gnt, bif.dm_gnt, bif.if_gnt}, 64'(exp_g));
    chk("mem_en",    64'(bif.mem_en), 64'(w != 0));
    chk("mem_we",    64'(bif.mem_we), 64'(e_we));
    chk("mem_addr",  64'(bif.mem_addr), 64'(e_addr));
    chk("mem_wdata", 64'(bif.mem_wdata), 64'(e_wd));
    chk("locked",    64'(bif.locked), 64'(exp_lock));

    if (w != 0) begin
      if (e_we) ref_mem[e_addr] = e_wd;
      else begin
        e.own  = w;
        e.data = ref_mem[e_addr];
        sb.push_back(e);
      end
    end
  endtask

  task automatic cyc(input int w);
    @(negedge clk);
    check_cycle(w);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bif.ld_req = 1'b0; bif.dm_req = 1'b0; bif.if_req = 1'b0;
    bif.ld_we  = 1'b0; bif.dm_we  = 1'b0;
    bif.ld_wdata = '0; bif.dm_wdata = '0;
  endtask

  initial begin
    logic [DW-1:0] prog [8];
    int            da;
    prog[0] = 32'h28010078; prog[1] = 32'h00000011; prog[2] = 32'h20220000;
    prog[3] = 32'hdeadbeef; prog[4] = 32'h12345678; prog[5] = 32'h0badf00d;
    prog[6] = 32'hcafe0006; prog[7] = 32'h77777777;

    rst_n = 1'b0;
    idle_reqs();
    bif.ld_addr = '0; bif.dm_addr = '0; bif.if_addr = '0;
    bif.ld_lock = 1'b0; bif.cpu_halted = 1'b0;
    exp_lock = 1'b0;
    #3;
    check_cycle(0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Loader write then data-stage read of the same word
    bif.ld_req = 1'b1; bif.ld_we = 1'b1; bif.ld_addr = 10'd120; bif.ld_wdata = 32'd85;
    cyc(1);
    idle_reqs();
    bif.dm_req = 1'b1; bif.dm_addr = 10'd120;
    cyc(2);
    idle_reqs();
    cyc(0);
    cyc(0);

    // Locked program download while dm and fetch are held
    bif.ld_lock = 1'b1;
    bif.dm_req = 1'b1; bif.dm_addr = 10'd0;
    bif.if_req = 1'b1; bif.if_addr = 10'd0;
    for (int i = 0; i < 8; i++) begin
      bif.ld_req = 1'b1; bif.ld_we = 1'b1;
      bif.ld_addr = AW'(i); bif.ld_wdata = prog[i];
      exp_lock = (i != 0);
      cyc(1);
    end
    bif.ld_req = 1'b0; bif.ld_we = 1'b0; bif.ld_lock = 1'b0;
    exp_lock = 1'b1;
    cyc(0);
    exp_lock = 1'b0;
    cyc(2);
    bif.dm_req = 1'b0;
    cyc(3);
    bif.if_req = 1'b0;
    cyc(0);
    cyc(0);

    // Fetch starvation boost with dm and fetch held
    da = 0;
    bif.dm_req = 1'b1; bif.if_req = 1'b1; bif.if_addr = 10'd2;
    for (int i = 0; i < 10; i++) begin
      bif.dm_addr = AW'(da);
      if (i % 5 == 4) cyc(3);
      else begin
        cyc(2);
        da++;
      end
    end
    idle_reqs();
    cyc(0);

    // Fetch read in flight when the core halts, then halted fetch ignored
    bif.if_req = 1'b1; bif.if_addr = 10'd2;
    cyc(3);
    bif.cpu_halted = 1'b1;
    bif.dm_addr = 10'd120;
    for (int i = 0; i < 10; i++) begin
      bif.dm_req = (i == 3 || i == 7);
      cyc((i == 3 || i == 7) ? 2 : 0);
    end
    bif.cpu_halted = 1'b0;
    bif.dm_req = 1'b1;
    for (int i = 0; i < 5; i++) cyc((i == 4) ? 3 : 2);
    idle_reqs();
    cyc(0);

    // Alternating fetch / data reads pipeline without crossing data
    for (int i = 0; i < 6; i++) begin
      bif.if_req = (i % 2 == 0); bif.if_addr = 10'd2;
      bif.dm_req = (i % 2 == 1); bif.dm_addr = 10'd120;
      cyc((i % 2 == 0) ? 3 : 2);
    end
    idle_reqs();
    cyc(0);

    // Reset asserted while a dm read is outstanding
    bif.dm_req = 1'b1; bif.dm_addr = 10'd120;
    @(negedge clk);
    check_cycle(2);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_cycle(0);
    @(posedge clk); #1;
    check_cycle(0);
    idle_reqs();
    rst_n = 1'b1;
    cyc(0);
    bif.dm_req = 1'b1; bif.dm_addr = 10'd120;
    cyc(2);
    idle_reqs();
    cyc(0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
